uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters (2..8).
REQ-002 Parameter TIMEOUT_CYC, default 1_000_000: cycles a granted requester may stall before its frame is aborted.
REQ-003 Reset is synchronous and active-low on a single clock: clk and rst, where rst=0 resets on the next rising clk.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 rst  in  1  synchronous active-low reset.
REQ-006 req_valid  in  N_REQ  per-requester byte valid.
REQ-007 req_data  in  8*N_REQ  per-requester byte; requester i uses bits [8i+7:8i].
REQ-008 req_last  in  N_REQ  marks the final byte of a frame.
REQ-009 req_ready  out  N_REQ  byte accepted this cycle; at most one bit is high.
REQ-010 tx_full  in  1  full flag of the downstream UART TX FIFO.
REQ-011 push_tx  out  1  push strobe into the UART TX FIFO.
REQ-012 tx_din  out  8  byte pushed into the UART TX FIFO.
REQ-013 grant_id  out  $clog2(N_REQ)  current or most recent owner.
REQ-014 busy  out  1  a frame is in progress.
REQ-015 abort_pulse  out  1  one-cycle pulse when a frame is aborted; present only with the macro in REQ-031.

Function
REQ-016 FSM states are IDLE and SEND; frame-level locking; a byte-level interleave of frames never occurs.
REQ-017 In IDLE, if any req_valid bit is high, the block selects a winner by round-robin, searching from (last_grant+1) mod N_REQ upward with wrap-around, registers it into grant_id, sets busy=1 and moves to SEND on the next edge.
REQ-018 IDLE is never acceptance: req_ready=0 and push_tx=0 in IDLE, so the first byte can be pushed 1 cycle after valid is first seen.
REQ-019 In SEND, the following are combinational:
  - push_tx = req_valid[grant_id] & ~tx_full
  - req_ready[grant_id] = push_tx
  - tx_din = req_data of grant_id
REQ-020 When tx_full=1, push_tx=0 and the byte is held; it is neither dropped nor duplicated.
REQ-021 On a cycle with push_tx=1 and req_last[grant_id]=1, the block updates last_grant to grant_id, goes to IDLE with busy=0 and re-arbitrates, so back-to-back frames have a 1-cycle gap.
REQ-022 The grant is never pre-empted mid-frame, regardless of other req_valid bits.
REQ-023 A single requester that is repeatedly valid wins every arbitration.
REQ-024 When all requesters are valid, grants rotate strictly i, i+1, ... mod N_REQ.
REQ-025 A frame of one byte (valid and last together on the first byte) is legal and completes in 1 SEND cycle.
REQ-026 req_valid bits of non-granted requesters are ignored in SEND; their req_ready stays 0.
REQ-027 If N_REQ is not a power of two, round-robin wrap-around skips indices at or above N_REQ.

Reset
REQ-028 While rst=0, the block holds the following state; frames in progress are discarded with no partial push afterwards:
  - state = IDLE
  - last_grant = N_REQ-1, so requester 0 has first priority
  - grant_id = 0
  - busy = 0
  - push_tx = 0
  - req_ready = 0
  - tx_din = 0
  - abort_pulse = 0
  - timeout counter = 0
REQ-029 If reset is asserted mid-frame, the next cycle after release is IDLE and arbitration restarts from requester 0.

Configuration
REQ-030 The macro UART_ARB_TIMEOUT_EN compiles the stall watchdog in or out.
REQ-031 With UART_ARB_TIMEOUT_EN defined:
  - a counter clears on every push and on SEND entry
  - it increments each SEND cycle with req_valid[grant_id]=0; tx_full stalls are not counted
  - when the count reaches TIMEOUT_CYC-1, the block pulses abort_pulse for 1 cycle, updates last_grant to grant_id and goes to IDLE
REQ-032 Without the macro, there is no counter, the abort_pulse port is absent, and a stalled owner holds the grant indefinitely.

Structure
REQ-033 Shared package uart_arb_pkg holds the FSM state encoding (IDLE=0, SEND=1) and the default values of N_REQ and TIMEOUT_CYC.
REQ-034 Sub-module rr_arbiter is a registered-free combinational round-robin pick; inputs are the request vector and last_grant, outputs are winner index and any_req. It is instantiated once.
REQ-035 The top level holds the FSM, grant registers, output mux and the optional watchdog.

Verification
REQ-036 Reset release, requester 0 sends 3 bytes 0x41,0x42,0x0A (last on 0x0A), tx_full=0 -> push_tx high 3 consecutive cycles starting 1 cycle after valid; tx_din sequence 41,42,0A; then busy=0.
REQ-037 All 4 requesters continuously valid with 1-byte frames -> grant_id sequence 0,1,2,3,0, with push_tx every other cycle.
REQ-038 Requester 2 mid-frame with tx_full=1 for 5 cycles, requester 1 valid -> no push for 5 cycles, requester 1 not granted, byte held, frame completes, then requester 1 is granted.
REQ-039 Reset pulled low for 1 cycle during byte 2 of a 4-byte frame from requester 3 -> busy=0, push_tx=0 next cycle; after release, requester 0 wins if it is valid.
REQ-040 With UART_ARB_TIMEOUT_EN and TIMEOUT_CYC=16, requester 1 drops valid after byte 1 -> abort_pulse 1 cycle, 16 cycles after the last push; next grant goes to requester 2 if it is valid.
REQ-041 Without the macro, same stimulus as REQ-040 -> grant held for 100 cycles, and the design compiles with no abort_pulse port.

Source files
------------

// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: FSM state encoding and default sizing shared by uart_tx_arbiter.
package uart_arb_pkg;
    localparam logic [0:0] IDLE            = 1'b0;
    localparam logic [0:0] SEND            = 1'b1;
    localparam int         N_REQ_DEF       = 4;
    localparam int         TIMEOUT_CYC_DEF = 1_000_000;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last+1 with wrap at N.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N = N_REQ_DEF,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] winner,
    output logic         any_req
);
    // Descending scan so the closest index after last is written last and wins.
    always_comb begin
        winner = '0;
        for (int k = N; k >= 1; k--)
            if (req[(int'(last) + k) % N]) winner = W'((int'(last) + k) % N);
    end
    assign any_req = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: frame-locked round-robin arbiter feeding a UART TX FIFO.
// Stall watchdog and abort_pulse port are compiled in with UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int W = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]   req_last,
    output logic [N_REQ-1:0]   req_ready,
    input  logic               tx_full,
    output logic               push_tx,
    output logic [7:0]         tx_din,
    output logic [W-1:0]       grant_id,
`ifdef UART_ARB_TIMEOUT_EN
    output logic               abort_pulse,
`endif
    output logic               busy
);
    logic [0:0]   state_q, state_d;
    logic [W-1:0] grant_q, grant_d, last_q, last_d, winner;
    logic         any_req, send, push, abort, fin;

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("uart_tx_arbiter: N_REQ must be 2..8 and TIMEOUT_CYC at least 2");
    end

    rr_arbiter #(.N(N_REQ)) u_rr (
        .req     (req_valid),
        .last    (last_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Outputs are gated by rst so nothing leaks out during the reset cycle itself.
    assign send      = rst && state_q == SEND;
    assign push      = send && req_valid[grant_q] && !tx_full;
    assign push_tx   = push;
    assign req_ready = push ? N_REQ'(1) << grant_q : '0;
    assign tx_din    = send ? req_data[8*grant_q +: 8] : '0;
    assign grant_id  = grant_q;
    assign busy      = send;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC);
    logic [CW-1:0] cnt_q, cnt_d;
    assign abort       = send && !req_valid[grant_q] && cnt_q == CW'(TIMEOUT_CYC - 1);
    assign abort_pulse = abort;
    // Only owner-idle cycles count; FIFO back-pressure never trips the watchdog.
    always_comb cnt_d = (!send || push) ? '0 : (!req_valid[grant_q] ? cnt_q + 1'b1 : cnt_q);
    always_ff @(posedge clk) cnt_q <= rst ? cnt_d : '0;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        fin     = send && ((push && req_last[grant_q]) || abort);
        state_d = send ? (fin ? IDLE : SEND) : (any_req ? SEND : IDLE);
        grant_d = (!send && any_req) ? winner : grant_q;
        last_d  = fin ? grant_q : last_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= W'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed stimulus with a push scoreboard; define UART_ARB_TIMEOUT_EN
// to exercise the watchdog variant.
module tb_uart_tx_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid, req_last, req_ready;
    logic [31:0] req_data;
    logic        tx_full, push_tx, busy;
    logic [7:0]  tx_din;
    logic [1:0]  grant_id;
`ifdef UART_ARB_TIMEOUT_EN
    logic        abort_pulse;
`endif

    uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYC(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_full     (tx_full),
        .push_tx     (push_tx),
        .tx_din      (tx_din),
        .grant_id    (grant_id),
`ifdef UART_ARB_TIMEOUT_EN
        .abort_pulse (abort_pulse),
`endif
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int          cyc = 0;
    int          n_vec = 0, n_err = 0;
    logic [11:0] sb[$];
    int          pc[$];
    int          ac[$];
    logic [8:0]  fq[4][$];
    int          start;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < 4; i++) begin
            req_valid[i]       = fq[i].size() > 0;
            req_data[8*i +: 8] = fq[i].size() > 0 ? fq[i][0][7:0] : 8'h00;
            req_last[i]        = fq[i].size() > 0 ? fq[i][0][8] : 1'b0;
        end
    endtask

    task automatic send(input int r, input logic [7:0] d, input logic last);
        fq[r].push_back({last, d});
    endtask

    task automatic expect_push(input int id, input logic [7:0] d);
        sb.push_back({4'(id), d});
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) fq[i].delete();
        refresh();
        tick();
        tick();
        rst = 1'b1;
    endtask

    // Requester model: pop the head byte after each cycle its req_ready was high.
    initial begin
        logic [3:0] acc;
        forever begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++)
                if (acc[i] && fq[i].size() > 0) void'(fq[i].pop_front());
            refresh();
        end
    end

    // Monitor: every push must match the next scoreboard entry.
    initial begin
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (push_tx) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_push: got id %0d data %0h, required no push", grant_id, tx_din);
                end else begin
                    e = sb.pop_front();
                    chk("push_id", 32'(grant_id), 32'(e[11:8]));
                    chk("push_data", 32'(tx_din), 32'(e[7:0]));
                    chk("push_ready", 32'(req_ready), 32'(1) << e[11:8]);
                end
                pc.push_back(cyc);
            end else begin
                chk("idle_ready", 32'(req_ready), 32'h0);
            end
            if (tx_full) chk("full_no_push", 32'(push_tx), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
            if (abort_pulse) ac.push_back(cyc);
`endif
        end
    end

    initial begin
        rst = 1'b0;
        tx_full = 1'b0;
        refresh();
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_push", 32'(push_tx), 32'h0);
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_din", 32'(tx_din), 32'h0);
        chk("rst_grant", 32'(grant_id), 32'h0);
        rst = 1'b1;
        tick();

        // Three-byte frame from requester 0, pushes on three consecutive cycles.
        pc.delete();
        start = cyc;
        send(0, 8'h41, 1'b0); send(0, 8'h42, 1'b0); send(0, 8'h0A, 1'b1);
        expect_push(0, 8'h41); expect_push(0, 8'h42); expect_push(0, 8'h0A);
        refresh();
        tick();
        chk("f0_busy", 32'(busy), 32'h1);
        repeat (5) tick();
        chk("f0_done_busy", 32'(busy), 32'h0);
        chk("f0_npush", pc.size(), 3);
        if (pc.size() == 3) begin
            chk("f0_first_cyc", pc[0], start + 1);
            chk("f0_last_cyc", pc[2], start + 3);
        end

        // All requesters valid with one-byte frames: strict rotation 0,1,2,3,0.
        do_reset();
        tick();
        pc.delete();
        start = cyc;
        send(0, 8'h10, 1'b1); send(1, 8'h11, 1'b1); send(2, 8'h12, 1'b1);
        send(3, 8'h13, 1'b1); send(0, 8'h14, 1'b1);
        expect_push(0, 8'h10); expect_push(1, 8'h11); expect_push(2, 8'h12);
        expect_push(3, 8'h13); expect_push(0, 8'h14);
        refresh();
        repeat (12) tick();
        chk("rr_npush", pc.size(), 5);
        for (int k = 0; k < 5 && k < pc.size(); k++) chk("rr_cyc", pc[k], start + 1 + 2*k);

        // Requester 2 stalled by tx_full mid-frame while requester 1 waits.
        pc.delete();
        start = cyc;
        send(2, 8'h21, 1'b0); send(2, 8'h22, 1'b0); send(2, 8'h23, 1'b1);
        expect_push(2, 8'h21); expect_push(2, 8'h22); expect_push(2, 8'h23);
        expect_push(1, 8'h31);
        refresh();
        tick();
        tick();
        tx_full = 1'b1;
        send(1, 8'h31, 1'b1);
        refresh();
        repeat (5) tick();
        chk("stall_busy", 32'(busy), 32'h1);
        chk("stall_grant", 32'(grant_id), 32'h2);
        chk("stall_held_din", 32'(tx_din), 32'h22);
        tx_full = 1'b0;
        repeat (6) tick();
        chk("stall_npush", pc.size(), 4);
        if (pc.size() == 4) begin
            chk("stall_resume_cyc", pc[1], start + 7);
            chk("stall_next_cyc", pc[3], start + 10);
        end

        // One-cycle reset during byte 2 of a 4-byte frame from requester 3.
        pc.delete();
        start = cyc;
        send(3, 8'h51, 1'b0); send(3, 8'h52, 1'b0); send(3, 8'h53, 1'b0); send(3, 8'h54, 1'b1);
        expect_push(3, 8'h51);
        refresh();
        tick();
        tick();
        rst = 1'b0;
        fq[3].delete();
        refresh();
        tick();
        rst = 1'b1;
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_push", 32'(push_tx), 32'h0);
        send(0, 8'h60, 1'b1); send(3, 8'h61, 1'b1);
        expect_push(0, 8'h60); expect_push(3, 8'h61);
        refresh();
        repeat (6) tick();
        chk("midrst_npush", pc.size(), 3);
        if (pc.size() == 3) chk("midrst_first_cyc", pc[1], start + 4);

        // Requester 1 goes silent after its first byte; requester 2 is waiting.
        pc.delete();
        ac.delete();
        start = cyc;
        send(1, 8'h71, 1'b0); send(2, 8'h72, 1'b1);
        expect_push(1, 8'h71);
`ifdef UART_ARB_TIMEOUT_EN
        expect_push(2, 8'h72);
`endif
        refresh();
        repeat (25) tick();
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_naborts", ac.size(), 1);
        if (ac.size() == 1) chk("to_abort_cyc", ac[0], start + 17);
        chk("to_npush", pc.size(), 2);
        if (pc.size() == 2) chk("to_next_cyc", pc[1], start + 19);
        chk("to_grant", 32'(grant_id), 32'h2);
`else
        repeat (100) tick();
        chk("hold_busy", 32'(busy), 32'h1);
        chk("hold_grant", 32'(grant_id), 32'h1);
        chk("hold_npush", pc.size(), 1);
`endif
        chk("sb_drained", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
